// File: rtl/rvmyth_out_capture.sv
// Change capture for the RVMYTH OUT bus: samples cpu_out, queues each value change into a FWFT FIFO.
// Optional timestamps: define RVMYTH_OUT_CAPTURE_TS_EN to store a free-running cycle count per entry.
module rvmyth_out_capture #(
  parameter int DATA_W = 10,
  parameter int DEPTH  = 16,
  parameter int TS_W   = 16
) (
  input  logic                       CLK,
  input  logic                       reset,
  input  logic [DATA_W-1:0]          cpu_out,
  input  logic                       en,
  input  logic                       ovf_clr,
  input  logic                       rd_ready,
  output logic                       rd_valid,
  output logic [DATA_W-1:0]          rd_data,
  output logic [TS_W-1:0]            rd_ts,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       overflow,
  output logic [7:0]                 drop_cnt
);
  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] s_q, s_d, prev_q, prev_d;
  logic              prev_vld_q, prev_vld_d;
  logic [AW:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic              overflow_q, overflow_d;
  logic [7:0]        drop_cnt_q, drop_cnt_d;
  logic [DATA_W-1:0] mem_data [DEPTH];
  logic              change, full, empty, push, pop, drop;

  assign empty  = (wr_ptr_q == rd_ptr_q);
  assign full   = (wr_ptr_q == {~rd_ptr_q[AW], rd_ptr_q[AW-1:0]});
  assign change = en && (!prev_vld_q || (s_q != prev_q));
  assign pop    = !empty && rd_ready;
  // A pop on the same edge frees the slot, so a full FIFO still accepts the push.
  assign push   = change && (!full || pop);
  assign drop   = change && full && !pop;

  always_comb begin
    s_d        = cpu_out;
    prev_d     = prev_q;
    prev_vld_d = prev_vld_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    overflow_d = overflow_q;
    drop_cnt_d = drop_cnt_q;
    if (!en) begin
      prev_vld_d = 1'b0;
    end else if (change) begin
      prev_d     = s_q;
      prev_vld_d = 1'b1;
    end
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    if (ovf_clr) begin
      overflow_d = drop;
      drop_cnt_d = drop ? 8'd1 : 8'd0;
    end else if (drop) begin
      overflow_d = 1'b1;
      if (drop_cnt_q != 8'hFF) drop_cnt_d = drop_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      s_q        <= '0;
      prev_q     <= '0;
      prev_vld_q <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      s_q        <= s_d;
      prev_q     <= prev_d;
      prev_vld_q <= prev_vld_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      overflow_q <= overflow_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (push) mem_data[wr_ptr_q[AW-1:0]] <= s_q;
  end

  assign rd_valid = !empty;
  assign rd_data  = empty ? '0 : mem_data[rd_ptr_q[AW-1:0]];
  assign level    = wr_ptr_q - rd_ptr_q;
  assign overflow = overflow_q;
  assign drop_cnt = drop_cnt_q;

`ifdef RVMYTH_OUT_CAPTURE_TS_EN
  logic [TS_W-1:0] ts_cnt_q, ts_cnt_d;
  logic [TS_W-1:0] mem_ts [DEPTH];

  always_comb ts_cnt_d = ts_cnt_q + 1'b1;

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) ts_cnt_q <= '0;
    else        ts_cnt_q <= ts_cnt_d;
  end

  always_ff @(posedge CLK) begin
    if (push) mem_ts[wr_ptr_q[AW-1:0]] <= ts_cnt_q;
  end

  assign rd_ts = empty ? '0 : mem_ts[rd_ptr_q[AW-1:0]];
`else
  assign rd_ts = '0;
`endif

endmodule

// File: doc/rvmyth_out_capture.md
Name: rvmyth_out_capture

Overview:
- Receiving end of the CPU's 10-bit OUT bus: samples the bus every cycle and records each value change.
- Each change is stored as an entry, optionally with a timestamp, in a first-word-fall-through FIFO.
- The FIFO is drained by a valid/ready reader, such as a UART bridge or a bench scoreboard.
- Sits beside the CPU in the top level, on the CPU's CLK, and replaces waveform-only observation of OUT.

Parameters:
- DATA_W, 10, width of the captured CPU output bus.
- DEPTH, 16, FIFO entries; power of two, at least 2.
- TS_W, 16, timestamp width in cycles.

Ports:
- CLK  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset; 0 clears all state immediately.
- cpu_out  input  DATA_W  CPU OUT bus, synchronous to CLK.
- en  input  1  capture enable.
- ovf_clr  input  1  single-cycle pulse; clears overflow and drop_cnt.
- rd_ready  input  1  reader accepts the head entry.
- rd_valid  output  1  FIFO non-empty; head entry present on rd_data/rd_ts.
- rd_data  output  DATA_W  captured value at FIFO head.
- rd_ts  output  TS_W  timestamp of the head entry.
- level  output  $clog2(DEPTH)+1  current entry count.
- overflow  output  1  sticky; set when a change is dropped.
- drop_cnt  output  8  dropped-change count, saturating at 255.

Behaviour:
- Reset (reset=0, asynchronous): rd_valid=0, rd_data=0, rd_ts=0, level=0, overflow=0, drop_cnt=0.
  - Also cleared: s_reg, prev, prev_vld, ts_cnt and the FIFO pointers.
  - Applies mid-transfer too; the FIFO contents are discarded.
- Stage 1, every edge: s_reg <= cpu_out.
- Stage 2, change detect:
  - change = en && (!prev_vld || s_reg != prev).
  - On an edge with change=1: prev <= s_reg, prev_vld <= 1, and the push of {ts_cnt, s_reg} is attempted.
- Latency: if cpu_out changes before edge k, the entry is written at edge k+1 and rd_valid=1 after edge k+1.
  - There is no empty-FIFO bypass.
- Glitch handling: a value that holds for exactly one cycle is captured. A→B→A produces entries B and A.
- en=0: no pushes and prev_vld <= 0.
  - On re-enable, the first s_reg value is captured even if it equals the old prev.
  - Pops continue while en=0.
- Pop: occurs on an edge with rd_valid && rd_ready. The next entry appears the following cycle.
- Output stability: rd_data/rd_ts stay stable while rd_valid=1 and rd_ready=0.
- Full, push with no pop:
  - The entry is dropped and overflow <= 1.
  - drop_cnt increments, saturating at 255.
  - prev is still updated, so the next change compares against the dropped value.
- Full, push with pop on the same edge: both take effect and level stays at DEPTH.
- Empty, pop request: ignored because rd_valid=0.
- level: +1 on push only, -1 on pop only, unchanged on both or neither.
- ovf_clr: clears overflow and drop_cnt.
  - If a drop occurs on the same edge, the result is overflow=1, drop_cnt=1.
- Pointers wrap modulo DEPTH. An extra MSB distinguishes full from empty.

Optional Feature:
- Macro: RVMYTH_OUT_CAPTURE_TS_EN.
- Defined:
  - ts_cnt is a free-running TS_W counter: 0 after reset, +1 every cycle regardless of en, wraps to 0.
  - Each entry stores the ts_cnt value present before the push edge.
  - rd_ts carries the stored value.
- Undefined:
  - No counter and no timestamp storage.
  - rd_ts is tied to 0; the port is kept for interface stability.

Test Plan:
- Reset, then cpu_out=10'h000 held, en=1 -> exactly one entry 0x000; 10 idle cycles add nothing; level=1.
- cpu_out steps 0x001, 0x002, 0x3FF on consecutive cycles, rd_ready=0 -> level reaches 3 and later entries stay queued.
  - rd_data shows 0x001 two edges after the first change.
  - After draining, the order is 0x001, 0x002, 0x3FF.
  - With TS_EN, timestamps are consecutive (t, t+1, t+2).
- 20 distinct changes, DEPTH=16, rd_ready=0 -> level=16, overflow=1, drop_cnt=4.
  - ovf_clr pulse -> overflow=0, drop_cnt=0, level stays 16.
- Full FIFO, rd_ready=1 held while changes continue every cycle -> no drops, level=16 constant, output order preserved.
- en=0 while cpu_out changes 0x055→0x0AA -> no entries.
  - Re-enable with cpu_out=0x0AA -> a single entry 0x0AA.
- Async reset asserted mid-drain with level=5 -> rd_valid, level and overflow go to 0 before the next edge.
  - After release, the held cpu_out value is captured as a new first entry.
